// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus request sequencer feeding a one-frame-at-a-time UART TX controller.
// Latency: a write into an idle, empty feeder raises o_Tx_Ready two edges later (push, then pop/request).
// Backpressure: writes to a full FIFO are dropped and flagged in the sticky o_Overflow, unless a pop frees a slot that cycle.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_Wr_En, i_Wr_Data        host write strobe and byte
//   i_Clr_Ovf                 clears the sticky overflow flag (a same-cycle overflow wins)
//   o_Full, o_Empty, o_Count  registered FIFO status, derived from the next-count value
//   o_Overflow                sticky: a write was rejected
//   o_Busy                    a byte is in flight (REQ or BUSY)
//   o_Tx_Byte, o_Tx_Ready     byte and start request to the TX controller
//   i_Tx_Active, i_Tx_Done    TX controller frame-active flag and one-cycle frame-complete pulse

module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  input  logic              i_Clr_Ovf,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic [7:0]        o_Tx_Byte,
  output logic              o_Tx_Ready,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  // FIFO storage (no reset needed: contents are only read when count says valid)
  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_ready_q, tx_ready_d;
  state_t            state_q, state_d;

  logic              pop;
  logic              push;

  always_comb begin
    // The only consumer of the FIFO is the IDLE->REQ transition.
    pop  = (state_q == ST_IDLE) && !empty_q;
    // A pop in the same cycle frees the head slot, so a write at full still fits.
    push = i_Wr_En && (!full_q || pop);

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    // Flags come from the next count so they are valid the cycle after the update.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);

    // Set has priority over clear so a rejected write is never lost.
    ovf_d = ovf_q;
    if (i_Wr_En && !push) begin
      ovf_d = 1'b1;
    end else if (i_Clr_Ovf) begin
      ovf_d = 1'b0;
    end

    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    tx_ready_d = tx_ready_q;
    case (state_q)
      ST_IDLE: begin
        tx_ready_d = 1'b0;
        if (!empty_q) begin
          tx_byte_d  = mem_q[rd_ptr_q];
          tx_ready_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // Hold the request until the controller acknowledges by going active;
        // a stray done pulse here cannot belong to this byte.
        tx_ready_d = 1'b1;
        if (i_Tx_Active) begin
          tx_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tx_ready_d = 1'b0;
        if (i_Tx_Done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_ready_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_REQ) || (state_d == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Wr_Data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_ready_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      tx_byte_q  <= tx_byte_d;
      tx_ready_q <= tx_ready_d;
      state_q    <= state_d;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Busy     = busy_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Tx_Ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized and directed stimulus against a queue-based model of the feeder.
// A small bench-side UART TX controller answers requests and logs the serial line.
// All outputs are compared with the model on every falling edge while out of reset.

module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_Wr_En = 1'b0;
  logic [7:0]        i_Wr_Data = 8'h00;
  logic              i_Clr_Ovf = 1'b0;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_Busy;
  logic [7:0]        o_Tx_Byte;
  logic              o_Tx_Ready;
  logic              i_Tx_Active = 1'b0;
  logic              i_Tx_Done = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Data  (i_Wr_Data),
    .i_Clr_Ovf  (i_Clr_Ovf),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .o_Busy     (o_Busy),
    .o_Tx_Byte  (o_Tx_Byte),
    .o_Tx_Ready (o_Tx_Ready),
    .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done  (i_Tx_Done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];         // bytes waiting in the FIFO
  logic [7:0] exp_start[$];   // bytes handed out, not yet started by the controller
  logic [7:0] started[$];     // bytes the controller actually started
  logic [7:0] wr_log[$];
  bit         line_log[$];
  bit         m_req = 1'b0;
  bit         m_inflight = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_txb = 8'h00;
  bit         m_pop, m_acc;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q.delete();
        exp_start.delete();
        m_req = 1'b0;
        m_inflight = 1'b0;
        m_ovf = 1'b0;
        m_txb = 8'h00;
      end else begin
        m_pop = !m_inflight && (m_q.size() > 0);
        m_acc = i_Wr_En && ((m_q.size() < DEPTH) || m_pop);
        if (m_pop) begin
          m_txb = m_q.pop_front();
          m_inflight = 1'b1;
          m_req = 1'b1;
          exp_start.push_back(m_txb);
        end else if (m_inflight && m_req && i_Tx_Active) begin
          m_req = 1'b0;
        end else if (m_inflight && !m_req && i_Tx_Done) begin
          m_inflight = 1'b0;
        end
        if (m_acc) m_q.push_back(i_Wr_Data);
        if (i_Wr_En && !m_acc) m_ovf = 1'b1;
        else if (i_Clr_Ovf) m_ovf = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  bit cmp_en = 1'b0;
  bit gap_chk = 1'b0;
  int cyc = 0;
  int last_done_cyc = -1;
  bit prev_rdy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && cmp_en) begin
        chk("count",  32'(o_Count), m_q.size());
        chk("empty",  32'(o_Empty), 32'(m_q.size() == 0));
        chk("full",   32'(o_Full), 32'(m_q.size() == DEPTH));
        chk("ovf",    32'(o_Overflow), 32'(m_ovf));
        chk("busy",   32'(o_Busy), 32'(m_inflight));
        chk("rdy",    32'(o_Tx_Ready), 32'(m_req));
        chk("txbyte", 32'(o_Tx_Byte), 32'(m_txb));
        if (gap_chk && o_Tx_Ready && !prev_rdy && last_done_cyc >= 0)
          chk("req_gap", cyc - last_done_cyc, 2);
        if (i_Tx_Done) last_done_cyc = cyc;
      end
      prev_rdy = o_Tx_Ready;
    end
  end

  // ---------------- bench-side TX controller ----------------
  bit         ctl_en = 1'b0;
  bit         man_active = 1'b0;
  bit         man_done = 1'b0;
  bit         c_rdy;
  logic [7:0] c_b;
  logic [9:0] c_sh;
  bit         c_fr = 1'b0;
  int         c_fc = 0;
  bit         tx_line = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      c_rdy = o_Tx_Ready;
      c_b   = o_Tx_Byte;
      @(posedge clk);
      #2;
      i_Tx_Done = 1'b0;
      if (!reset_n) begin
        i_Tx_Active = 1'b0;
        c_fr = 1'b0;
        tx_line = 1'b1;
      end else if (!ctl_en) begin
        i_Tx_Active = man_active;
        i_Tx_Done = man_done;
        c_fr = 1'b0;
      end else if (!c_fr) begin
        if (c_rdy) begin
          chk("start_pending", 32'(exp_start.size() > 0), 1);
          if (exp_start.size() > 0) chk("start_byte", c_b, exp_start.pop_front());
          started.push_back(c_b);
          c_sh = {1'b1, c_b, 1'b0};
          c_fr = 1'b1;
          c_fc = 0;
          i_Tx_Active = 1'b1;
          tx_line = c_sh[0];
          line_log.push_back(tx_line);
        end
      end else begin
        c_fc++;
        if (c_fc == 10) begin
          c_fr = 1'b0;
          i_Tx_Active = 1'b0;
          i_Tx_Done = 1'b1;
          tx_line = 1'b1;
        end else begin
          tx_line = c_sh[c_fc];
          line_log.push_back(tx_line);
        end
      end
    end
  end

  // ---------------- host-side helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    i_Wr_En = 1'b1;
    i_Wr_Data = d;
    step(1);
    i_Wr_En = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (o_Empty && !o_Busy && !i_Tx_Active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] b2b [3];
  bit         a5_line [10];
  int         hi;

  initial begin
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    a5_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    reset_n = 1'b0;
    step(3);
    chk("rst_count", 32'(o_Count), 0);
    chk("rst_empty", 32'(o_Empty), 1);
    chk("rst_full",  32'(o_Full), 0);
    chk("rst_ovf",   32'(o_Overflow), 0);
    chk("rst_busy",  32'(o_Busy), 0);
    chk("rst_byte",  32'(o_Tx_Byte), 0);
    chk("rst_rdy",   32'(o_Tx_Ready), 0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // Single byte through the live controller
    ctl_en = 1'b1;
    line_log.delete();
    started.delete();
    wr(8'hA5);
    chk("a5_count_e0", 32'(o_Count), 1);
    step(1);
    chk("a5_count_e1", 32'(o_Count), 0);
    chk("a5_byte", 32'(o_Tx_Byte), 32'h A5);
    chk("a5_rdy", 32'(o_Tx_Ready), 1);
    wait_idle(200);
    chk("a5_busy_clr", 32'(o_Busy), 0);
    chk("a5_line_len", line_log.size(), 10);
    for (int i = 0; i < 10 && i < line_log.size(); i++)
      chk("a5_line_bit", 32'(line_log[i]), 32'(a5_line[i]));
    chk("a5_starts", started.size(), 1);

    // Fill with the controller silent
    ctl_en = 1'b0;
    man_active = 1'b0;
    man_done = 1'b0;
    step(2);
    for (int i = 0; i <= 16; i++) begin
      i_Wr_En = 1'b1;
      i_Wr_Data = 8'(i);
      step(1);
    end
    i_Wr_En = 1'b0;
    chk("fill_count", 32'(o_Count), 16);
    chk("fill_full", 32'(o_Full), 1);
    chk("fill_ovf", 32'(o_Overflow), 0);
    chk("fill_head", 32'(o_Tx_Byte), 8'h00);
    wr(8'h99);
    chk("ovf_set", 32'(o_Overflow), 1);
    chk("ovf_count", 32'(o_Count), 16);
    i_Clr_Ovf = 1'b1;
    step(1);
    i_Clr_Ovf = 1'b0;
    chk("ovf_clr", 32'(o_Overflow), 0);

    // Push at full in the pop cycle
    man_active = 1'b1;
    void'(exp_start.pop_front());
    step(1);
    man_active = 1'b0;
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    i_Wr_En = 1'b1;
    i_Wr_Data = 8'hEE;
    step(1);
    i_Wr_En = 1'b0;
    chk("pf_count", 32'(o_Count), 16);
    chk("pf_ovf", 32'(o_Overflow), 0);
    chk("pf_byte", 32'(o_Tx_Byte), 8'h01);
    chk("pf_rdy", 32'(o_Tx_Ready), 1);

    // Drain everything through the controller
    ctl_en = 1'b1;
    wait_idle(2000);

    // Back-to-back frames
    started.delete();
    last_done_cyc = -1;
    gap_chk = 1'b1;
    for (int i = 0; i < 3; i++) wr(b2b[i]);
    wait_idle(500);
    gap_chk = 1'b0;
    chk("b2b_starts", started.size(), 3);
    for (int i = 0; i < 3 && i < started.size(); i++)
      chk("b2b_order", 32'(started[i]), 32'(b2b[i]));

    // Wrap-around with random write cadence
    started.delete();
    wr_log.delete();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      step($urandom_range(0, 8));
      for (int k = 0; k < 200 && o_Full; k++) step(1);
      d = 8'($urandom);
      wr_log.push_back(d);
      wr(d);
    end
    wait_idle(3000);
    chk("wrap_len", started.size(), 40);
    for (int i = 0; i < 40 && i < started.size(); i++)
      chk("wrap_data", 32'(started[i]), 32'(wr_log[i]));

    // Reset mid-frame
    for (int i = 0; i < 6; i++) wr(8'(8'h40 + i));
    chk("mf_busy", 32'(o_Busy), 1);
    chk("mf_count", 32'(o_Count), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mf_rst_rdy", 32'(o_Tx_Ready), 0);
    chk("mf_rst_count", 32'(o_Count), 0);
    chk("mf_rst_empty", 32'(o_Empty), 1);
    step(3);
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_Tx_Ready) hi++;
    end
    chk("mf_no_req", hi, 0);
    step(1);
    started.delete();
    wr(8'h5A);
    wait_idle(200);
    chk("mf_new_start", started.size(), 1);
    if (started.size() > 0) chk("mf_new_byte", 32'(started[0]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
